accum_status: RTL

//  Accumulation-interrupt status controller, directly downstream of the time base.

---
 rtl/accum_status.sv | 139 +++++++++++++
 1 files changed

// File: rtl/accum_status.sv
`default_nettype none
// ============================================================================
// Module      : accum_status
// Description : Accumulation-interrupt status controller. Collects per-channel
//               dump pulses and TIC events between consecutive accum_enable
//               pulses, snapshots them on each accum_enable and holds an
//               interrupt request until the processor reads status. Flags
//               overrun when a whole interval passes without a read.
// Optional    : ACCUM_MISS_CNT_EN -- builds the saturating missed-interrupt
//               counter; when undefined o_missed_cnt is tied to 0.
// Ports       :
//   clk              in   1       system clock
//   rstn             in   1       synchronous reset, active-low
//   i_accum_enable   in   1       1-cycle accumulation interrupt pulse
//   i_tic_enable     in   1       1-cycle TIC pulse
//   i_dump           in   NUM_CH  1-cycle per-channel dump pulses
//   i_status_rd      in   1       1-cycle processor status-read strobe
//   o_accum_int      out  1       interrupt request (registered level)
//   o_new_data       out  NUM_CH  channels that dumped in latched interval(s)
//   o_tic_flag       out  1       TIC occurred in latched interval(s)
//   o_overrun        out  1       interval(s) missed while interrupt pending
//   o_missed_cnt     out  MISS_W  saturating count of missed interrupts
// Revision    : 1.0 - initial release
// ============================================================================
module accum_status #(
  parameter int NUM_CH = 12,
  parameter int MISS_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_accum_enable,
  input  logic              i_tic_enable,
  input  logic [NUM_CH-1:0] i_dump,
  input  logic              i_status_rd,
  output logic              o_accum_int,
  output logic [NUM_CH-1:0] o_new_data,
  output logic              o_tic_flag,
  output logic              o_overrun,
  output logic [MISS_W-1:0] o_missed_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PEND    = 2'd1,
    ST_OVERRUN = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NUM_CH-1:0]   r_live_dump;
  logic [NUM_CH-1:0]   w_live_dump_nxt;
  logic                r_live_tic;
  logic                w_live_tic_nxt;
  logic [NUM_CH-1:0]   r_snap_dump;
  logic [NUM_CH-1:0]   w_snap_dump_nxt;
  logic                r_snap_tic;
  logic                w_snap_tic_nxt;
  logic                r_accum_int;
  logic                r_overrun;
  logic                w_miss;

  // An interval is missed when a new accum_enable arrives while the previous
  // interrupt is still pending and is not being read in this same cycle.
  assign w_miss = i_accum_enable && (r_state != ST_IDLE) && !i_status_rd;

  always_comb begin
    w_state_nxt     = r_state;
    w_snap_dump_nxt = r_snap_dump;
    w_snap_tic_nxt  = r_snap_tic;
    w_live_dump_nxt = r_live_dump | i_dump;
    w_live_tic_nxt  = r_live_tic | i_tic_enable;

    if (i_accum_enable) begin
      // Coincident dump/tic go into the snapshot, not the next interval.
      w_live_dump_nxt = '0;
      w_live_tic_nxt  = 1'b0;
      if (w_miss) begin
        w_snap_dump_nxt = r_snap_dump | r_live_dump | i_dump;
        w_snap_tic_nxt  = r_snap_tic | r_live_tic | i_tic_enable;
        w_state_nxt     = ST_OVERRUN;
      end else begin
        // Idle (snapshot already empty) or read in this cycle: the read
        // consumes the old snapshot, so the new one loads without merge.
        w_snap_dump_nxt = r_live_dump | i_dump;
        w_snap_tic_nxt  = r_live_tic | i_tic_enable;
        w_state_nxt     = ST_PEND;
      end
    end else if (i_status_rd) begin
      w_snap_dump_nxt = '0;
      w_snap_tic_nxt  = 1'b0;
      w_state_nxt     = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_live_dump <= '0;
      r_live_tic  <= 1'b0;
      r_snap_dump <= '0;
      r_snap_tic  <= 1'b0;
      r_accum_int <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_live_dump <= w_live_dump_nxt;
      r_live_tic  <= w_live_tic_nxt;
      r_snap_dump <= w_snap_dump_nxt;
      r_snap_tic  <= w_snap_tic_nxt;
      r_accum_int <= (w_state_nxt != ST_IDLE);
      r_overrun   <= (w_state_nxt == ST_OVERRUN);
    end
  end

  assign o_accum_int = r_accum_int;
  assign o_overrun   = r_overrun;
  assign o_new_data  = r_snap_dump;
  assign o_tic_flag  = r_snap_tic;

`ifdef ACCUM_MISS_CNT_EN
  logic [MISS_W-1:0] r_missed_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_missed_cnt <= '0;
    end else if (i_status_rd) begin
      r_missed_cnt <= '0;
    end else if (w_miss && (r_missed_cnt != {MISS_W{1'b1}})) begin
      r_missed_cnt <= r_missed_cnt + {{(MISS_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_missed_cnt = r_missed_cnt;
`else
  assign o_missed_cnt = '0;
`endif

endmodule
`default_nettype wire
